// File: rtl/mem_stage_lsu_pkg.sv
// Shared opcode and select codes, FSM state encoding and helpers for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  typedef logic [ALU_OP_W-1:0]  alu_op_t;
  typedef logic [ALU_SEL_W-1:0] alu_sel_t;

  localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
  localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
  localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
  localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
  localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
  localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
  localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
  localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;
  localparam alu_op_t EXE_ADD_OP = 8'b0010_0000;

  localparam alu_sel_t EXE_RES_ARITHMETIC = 3'b100;
  localparam alu_sel_t EXE_RES_LOAD_STORE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } lsu_state_t;

  function automatic logic is_load(input alu_op_t op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
           (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
  endfunction

  function automatic logic is_store(input alu_op_t op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic [2:0] op_bytes(input alu_op_t op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 3'd1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 3'd2;
      default:                          return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_ext.sv
// Width select and sign/zero extension of the little-endian assembled load word.
module mem_load_ext
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  alu_op_t     i_op,
  output logic [31:0] o_data
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves o_data unassigned (no latch).
    o_data = i_word;
    case (i_op)
      EXE_LB_OP:  o_data = {{24{i_word[7]}}, i_word[7:0]};
      EXE_LBU_OP: o_data = {24'h0, i_word[7:0]};
      EXE_LH_OP:  o_data = {{16{i_word[15]}}, i_word[15:0]};
      EXE_LHU_OP: o_data = {16'h0, i_word[15:0]};
      default:    o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: pass-through of ALU results, byte-serial loads/stores on an 8-bit RAM port.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  ready_o,
  input  alu_op_t               aluop_i,
  input  alu_sel_t              alusel_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic [REG_W-1:0]      mem_addr_i,
  input  logic [REG_W-1:0]      mem_sdata_i,
  output logic                  out_valid_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic [31:0]           mem_a_o,
  output logic [7:0]            mem_dout_o,
  output logic                  mem_wr_o,
  input  logic [7:0]            mem_din_i
);

  lsu_state_t  r_state;
  alu_op_t     r_op;
  logic [2:0]  r_nbytes;
  logic [2:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_lanes;
  logic [1:0]  r_cap_idx;
  logic [1:0]  r_rd_pipe;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_cap;
  logic        w_last_cap;
  logic [31:0] w_assembled;
  logic [31:0] w_ext;

  assign ready_o    = rst && (r_state == ST_IDLE);
  assign w_is_load  = (alusel_i == EXE_RES_LOAD_STORE) && is_load(aluop_i);
  assign w_is_store = (alusel_i == EXE_RES_LOAD_STORE) && is_store(aluop_i);

  // A read issued in RD returns MEM_RD_LAT cycles later; the pipe tracks which cycles carry data.
  assign w_cap      = (MEM_RD_LAT == 1) ? r_rd_pipe[0] : r_rd_pipe[1];
  assign w_last_cap = w_cap && ({1'b0, r_cap_idx} == (r_nbytes - 3'd1));

  always_comb begin
    w_assembled = r_lanes;
    if (w_cap) w_assembled[{r_cap_idx, 3'b000} +: 8] = mem_din_i;
  end

  mem_load_ext u_ext (
    .i_word (w_assembled),
    .i_op   (r_op),
    .o_data (w_ext)
  );

  // NOTE: every register here uses <= so all state advances together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_nbytes    <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_sdata     <= '0;
      r_lanes     <= '0;
      r_cap_idx   <= '0;
      r_rd_pipe   <= '0;
      out_valid_o <= 1'b0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
      mem_a_o     <= '0;
      mem_dout_o  <= '0;
      mem_wr_o    <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      r_rd_pipe   <= {r_rd_pipe[0], (r_state == ST_RD)};
      if (w_cap) begin
        r_lanes   <= w_assembled;
        r_cap_idx <= r_cap_idx + 2'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_op      <= aluop_i;
            r_nbytes  <= op_bytes(aluop_i);
            r_cnt     <= 3'd1;
            r_addr    <= mem_addr_i + 32'd1;
            r_lanes   <= '0;
            r_cap_idx <= '0;
            wd_o      <= wd_i;
            wreg_o    <= wreg_i && !w_is_store;
            wdata_o   <= wdata_i;
            if (w_is_load) begin
              r_state <= ST_RD;
              mem_a_o <= mem_addr_i;
            end else if (w_is_store) begin
              r_state    <= ST_WR;
              mem_a_o    <= mem_addr_i;
              mem_dout_o <= mem_sdata_i[7:0];
              mem_wr_o   <= 1'b1;
              r_sdata    <= mem_sdata_i >> 8;
            end else begin
              r_state     <= ST_DONE;
              out_valid_o <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (r_cnt == r_nbytes) begin
            r_state <= ST_WAIT;
          end else begin
            mem_a_o <= r_addr;
            r_addr  <= r_addr + 32'd1;
            r_cnt   <= r_cnt + 3'd1;
          end
        end
        ST_WAIT: begin
          if (w_last_cap) begin
            r_state     <= ST_DONE;
            out_valid_o <= 1'b1;
            wdata_o     <= w_ext;
          end
        end
        ST_WR: begin
          if (r_cnt == r_nbytes) begin
            r_state     <= ST_DONE;
            mem_wr_o    <= 1'b0;
            out_valid_o <= 1'b1;
          end else begin
            mem_a_o    <= r_addr;
            mem_dout_o <= r_sdata[7:0];
            r_sdata    <= r_sdata >> 8;
            r_addr     <= r_addr + 32'd1;
            r_cnt      <= r_cnt + 3'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one instance with MEM_RD_LAT=1, one with MEM_RD_LAT=2.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v1, v2;
  alu_op_t     aluop;
  alu_sel_t    alusel;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] wdata, addr, sdata;

  logic        rdy1, ov1, wreg1, wr1, rdy2, ov2, wreg2, wr2;
  logic [4:0]  wd1, wd2;
  logic [31:0] wdata1, a1, wdata2, a2;
  logic [7:0]  dout1, dout2, din1, din2, s2;

  logic [7:0]  ram [4096];
  logic [31:0] rec_a [64];
  logic [7:0]  rec_d [64];
  logic        rec_wr [64];
  logic        cur;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.MEM_RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid_i(v1), .ready_o(rdy1),
    .aluop_i(aluop), .alusel_i(alusel), .wd_i(wd), .wreg_i(wreg),
    .wdata_i(wdata), .mem_addr_i(addr), .mem_sdata_i(sdata),
    .out_valid_o(ov1), .wd_o(wd1), .wreg_o(wreg1), .wdata_o(wdata1),
    .mem_a_o(a1), .mem_dout_o(dout1), .mem_wr_o(wr1), .mem_din_i(din1)
  );

  mem_stage_lsu #(.MEM_RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid_i(v2), .ready_o(rdy2),
    .aluop_i(aluop), .alusel_i(alusel), .wd_i(wd), .wreg_i(wreg),
    .wdata_i(wdata), .mem_addr_i(addr), .mem_sdata_i(sdata),
    .out_valid_o(ov2), .wd_o(wd2), .wreg_o(wreg2), .wdata_o(wdata2),
    .mem_a_o(a2), .mem_dout_o(dout2), .mem_wr_o(wr2), .mem_din_i(din2)
  );

  // Read-only RAM model with one- and two-cycle read latency.
  always @(posedge clk) begin
    din1 <= ram[a1[11:0]];
    s2   <= ram[a2[11:0]];
    din2 <= s2;
  end

  wire        o_ov    = cur ? ov2    : ov1;
  wire        o_rdy   = cur ? rdy2   : rdy1;
  wire        o_wreg  = cur ? wreg2  : wreg1;
  wire        o_wr    = cur ? wr2    : wr1;
  wire [4:0]  o_wd    = cur ? wd2    : wd1;
  wire [31:0] o_wdata = cur ? wdata2 : wdata1;
  wire [31:0] o_a     = cur ? a2     : a1;
  wire [7:0]  o_d     = cur ? dout2  : dout1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int c);
    rec_a[c]  = o_a;
    rec_d[c]  = o_d;
    rec_wr[c] = o_wr;
  endtask

  task automatic drive(input alu_op_t op, input alu_sel_t sl, input logic [4:0] d,
                       input logic we, input logic [31:0] wdat, input logic [31:0] ad,
                       input logic [31:0] sd);
    aluop = op; alusel = sl; wd = d; wreg = we; wdata = wdat; addr = ad; sdata = sd;
  endtask

  // Issues one op, waits for out_valid_o, then checks latency, busy, result and return to idle.
  task automatic do_op(input logic sel, input string tag, input alu_op_t op, input alu_sel_t sl,
                       input logic [4:0] d, input logic we, input logic [31:0] wdat,
                       input logic [31:0] ad, input logic [31:0] sd, input int exp_cyc,
                       input logic [31:0] exp_wdata, input logic exp_wreg, input logic chk_data);
    int  cyc;
    logic busy_ok;
    cur = sel;
    drive(op, sl, d, we, wdat, ad, sd);
    if (sel) v2 = 1'b1; else v1 = 1'b1;
    tick;
    v1 = 1'b0; v2 = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!o_ov && cyc < 40) begin
      record(cyc);
      if (o_rdy) busy_ok = 1'b0;
      tick;
      cyc++;
    end
    record(cyc);
    if (o_rdy) busy_ok = 1'b0;
    check({tag, "_cyc"}, cyc, exp_cyc);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    if (chk_data) check({tag, "_wdata"}, o_wdata, exp_wdata);
    check({tag, "_wd"}, 32'(o_wd), 32'(d));
    check({tag, "_wreg"}, 32'(o_wreg), 32'(exp_wreg));
    tick;
    check({tag, "_ready_after"}, 32'(o_rdy), 32'd1);
    check({tag, "_ov_pulse"}, 32'(o_ov), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second;
    logic first_wreg;
    logic [31:0] second_wdata;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    ram[12'h020] = 8'h80; ram[12'h01F] = 8'h00;
    cur = 1'b0; rst = 1'b0; v1 = 1'b0; v2 = 1'b0;
    drive('0, '0, '0, 1'b0, '0, '0, '0);
    tick; tick;

    check("rst_ready", 32'(rdy1), 32'd0);
    check("rst_ov", 32'(ov1), 32'd0);
    check("rst_a", a1, 32'd0);
    check("rst_wr", 32'(wr1), 32'd0);
    check("rst_wdata", wdata1, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_ready", 32'(rdy1), 32'd1);

    // LW with LAT=1: address walk, result at c6.
    do_op(1'b0, "lw", EXE_LW_OP, EXE_RES_LOAD_STORE, 5'd4, 1'b1, 32'h0, 32'h100, 32'h0,
          6, 32'h12345678, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lw_a%0d", k), rec_a[k+1], 32'h100 + 32'(k));
      check($sformatf("lw_wr%0d", k), 32'(rec_wr[k+1]), 32'd0);
    end

    // Sign and zero extension.
    do_op(1'b0, "lb", EXE_LB_OP, EXE_RES_LOAD_STORE, 5'd6, 1'b1, 32'h0, 32'h20, 32'h0,
          3, 32'hFFFFFF80, 1'b1, 1'b1);
    do_op(1'b0, "lbu", EXE_LBU_OP, EXE_RES_LOAD_STORE, 5'd6, 1'b1, 32'h0, 32'h20, 32'h0,
          3, 32'h00000080, 1'b1, 1'b1);
    do_op(1'b0, "lh", EXE_LH_OP, EXE_RES_LOAD_STORE, 5'd7, 1'b1, 32'h0, 32'h1F, 32'h0,
          4, 32'hFFFF8000, 1'b1, 1'b1);
    do_op(1'b0, "lhu", EXE_LHU_OP, EXE_RES_LOAD_STORE, 5'd7, 1'b1, 32'h0, 32'h1F, 32'h0,
          4, 32'h00008000, 1'b1, 1'b1);

    // SW across the 2^32 wrap.
    do_op(1'b0, "sw", EXE_SW_OP, EXE_RES_LOAD_STORE, 5'd9, 1'b1, 32'h0, 32'hFFFFFFFE,
          32'hAABBCCDD, 5, 32'h0, 1'b0, 1'b0);
    check("sw_a1", rec_a[1], 32'hFFFFFFFE); check("sw_d1", 32'(rec_d[1]), 32'hDD);
    check("sw_a2", rec_a[2], 32'hFFFFFFFF); check("sw_d2", 32'(rec_d[2]), 32'hCC);
    check("sw_a3", rec_a[3], 32'h00000000); check("sw_d3", 32'(rec_d[3]), 32'hBB);
    check("sw_a4", rec_a[4], 32'h00000001); check("sw_d4", 32'(rec_d[4]), 32'hAA);
    for (int k = 1; k <= 4; k++) check($sformatf("sw_wr%0d", k), 32'(rec_wr[k]), 32'd1);
    check("sw_wr_done", 32'(rec_wr[5]), 32'd0);

    // ADD pass-through; mem_a_o keeps the last store address.
    do_op(1'b0, "add", EXE_ADD_OP, EXE_RES_ARITHMETIC, 5'd5, 1'b1, 32'd7, 32'h0, 32'h0,
          1, 32'd7, 1'b1, 1'b1);
    check("add_no_wr", 32'(rec_wr[1]), 32'd0);
    check("add_a_hold", rec_a[1], 32'h00000001);

    // Reset in c2 of a LW.
    cur = 1'b0;
    drive(EXE_LW_OP, EXE_RES_LOAD_STORE, 5'd4, 1'b1, 32'h0, 32'h100, 32'h0);
    v1 = 1'b1;
    tick;
    v1 = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    check("mrst_ov", 32'(ov1), 32'd0);
    check("mrst_wreg", 32'(wreg1), 32'd0);
    check("mrst_wd", 32'(wd1), 32'd0);
    check("mrst_wdata", wdata1, 32'd0);
    check("mrst_a", a1, 32'd0);
    check("mrst_dout", 32'(dout1), 32'd0);
    check("mrst_wr", 32'(wr1), 32'd0);
    check("mrst_ready", 32'(rdy1), 32'd0);
    rst = 1'b1;
    #1;
    check("mrst_ready_rel", 32'(rdy1), 32'd1);
    do_op(1'b0, "lbu_after_rst", EXE_LBU_OP, EXE_RES_LOAD_STORE, 5'd8, 1'b1, 32'h0, 32'h103,
          32'h0, 3, 32'h00000012, 1'b1, 1'b1);

    // in_valid_i held through a busy SH; the following ADD is taken only once ready.
    cur = 1'b0;
    drive(EXE_SH_OP, EXE_RES_LOAD_STORE, 5'd0, 1'b0, 32'h0, 32'h40, 32'h00001234);
    v1 = 1'b1;
    tick;
    drive(EXE_ADD_OP, EXE_RES_ARITHMETIC, 5'd3, 1'b1, 32'd9, 32'h0, 32'h0);
    first = 0; second = 0; first_wreg = 1'bx; second_wdata = 'x;
    for (int c = 1; c <= 8; c++) begin
      record(c);
      if (ov1) begin
        if (first == 0) begin
          first = c; first_wreg = wreg1;
        end else if (second == 0) begin
          second = c; second_wdata = wdata1;
        end
      end
      if (c == 5) v1 = 1'b0;
      tick;
    end
    check("hold_sh_cyc", first, 3);
    check("hold_sh_wreg", 32'(first_wreg), 32'd0);
    check("hold_add_cyc", second, 5);
    check("hold_add_wdata", second_wdata, 32'd9);
    check("hold_sh_a1", rec_a[1], 32'h40); check("hold_sh_d1", 32'(rec_d[1]), 32'h34);
    check("hold_sh_a2", rec_a[2], 32'h41); check("hold_sh_d2", 32'(rec_d[2]), 32'h12);

    // MEM_RD_LAT=2 instance.
    do_op(1'b1, "lw_lat2", EXE_LW_OP, EXE_RES_LOAD_STORE, 5'd4, 1'b1, 32'h0, 32'h100, 32'h0,
          7, 32'h12345678, 1'b1, 1'b1);
    do_op(1'b1, "lb_lat2", EXE_LB_OP, EXE_RES_LOAD_STORE, 5'd2, 1'b1, 32'h0, 32'h20, 32'h0,
          4, 32'hFFFFFF80, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
